// File: rtl/exu_wb_arbiter.sv
// EXU writeback merge: per-channel FIFOs feeding a round-robin arbiter and one registered regfile write port.
// Optional build macro EXU_WB_CONFLICT_CNT_EN adds conflict_cnt and stall_cnt debug counters.
module exu_wb_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int RD_W       = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_valid,
    output logic [NUM_CH-1:0]           ch_ready,
    input  logic [NUM_CH*XLEN-1:0]      ch_data,
    input  logic [NUM_CH*RD_W-1:0]      ch_rd_addr,
    input  logic [NUM_CH*XLEN-1:0]      ch_tag,
    input  logic [NUM_CH*32-1:0]        ch_instr,
    output logic                        wb_valid,
    output logic [XLEN-1:0]             wb_data,
    output logic [RD_W-1:0]             wb_rd_addr,
    output logic [XLEN-1:0]             wb_tag,
    output logic [31:0]                 wb_instr,
    output logic [$clog2(NUM_CH)-1:0]   wb_src,
    output logic                        pending
`ifdef EXU_WB_CONFLICT_CNT_EN
    ,
    output logic [31:0]                 conflict_cnt,
    output logic [NUM_CH*16-1:0]        stall_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_CH);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [XLEN-1:0]  mem_data  [NUM_CH][FIFO_DEPTH];
    logic [RD_W-1:0]  mem_rd    [NUM_CH][FIFO_DEPTH];
    logic [XLEN-1:0]  mem_tag   [NUM_CH][FIFO_DEPTH];
    logic [31:0]      mem_instr [NUM_CH][FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [CNT_W-1:0] count  [NUM_CH];

    logic [NUM_CH-1:0] head_valid;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] cand;
    logic             grant_valid;

    // Ready comes from the registered count only; x0 writes complete the handshake but never enqueue.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_ready[g]   = (count[g] < CNT_FULL);
        assign head_valid[g] = (count[g] != '0);
        assign push[g]       = ch_valid[g] & ch_ready[g] & (ch_rd_addr[g*RD_W +: RD_W] != '0);
        assign pop[g]        = grant_valid & (grant_idx == SRC_W'(g));
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!grant_valid && head_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_ONE;
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CNT_ONE;
                end
            end
        end
    end

    // Payload storage needs no reset: pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_data[i][wr_ptr[i]]  <= ch_data[i*XLEN +: XLEN];
                mem_rd[i][wr_ptr[i]]    <= ch_rd_addr[i*RD_W +: RD_W];
                mem_tag[i][wr_ptr[i]]   <= ch_tag[i*XLEN +: XLEN];
                mem_instr[i][wr_ptr[i]] <= ch_instr[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_rd_addr <= '0;
            wb_tag     <= '0;
            wb_instr   <= '0;
            wb_src     <= '0;
            rr_ptr     <= SRC_W'(NUM_CH - 1);
        end else begin
            wb_valid <= grant_valid;
            if (grant_valid) begin
                wb_data    <= mem_data[grant_idx][rd_ptr[grant_idx]];
                wb_rd_addr <= mem_rd[grant_idx][rd_ptr[grant_idx]];
                wb_tag     <= mem_tag[grant_idx][rd_ptr[grant_idx]];
                wb_instr   <= mem_instr[grant_idx][rd_ptr[grant_idx]];
                wb_src     <= grant_idx;
                rr_ptr     <= grant_idx;
            end
        end
    end

    assign pending = wb_valid | (|head_valid);

`ifdef EXU_WB_CONFLICT_CNT_EN
    logic multi_req;
    assign multi_req = ($countones(head_valid) > 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (multi_req && (conflict_cnt != 32'hFFFF_FFFF)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i] && !ch_ready[i] && (stall_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Self-checking bench for exu_wb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_exu_wb_arbiter;

    localparam int NUM_CH     = 4;
    localparam int XLEN       = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int RD_W       = 5;
    localparam int SRC_W      = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH-1:0]         ch_ready;
    logic [NUM_CH*XLEN-1:0]    ch_data;
    logic [NUM_CH*RD_W-1:0]    ch_rd_addr;
    logic [NUM_CH*XLEN-1:0]    ch_tag;
    logic [NUM_CH*32-1:0]      ch_instr;
    logic                      wb_valid;
    logic [XLEN-1:0]           wb_data;
    logic [RD_W-1:0]           wb_rd_addr;
    logic [XLEN-1:0]           wb_tag;
    logic [31:0]               wb_instr;
    logic [SRC_W-1:0]          wb_src;
    logic                      pending;
`ifdef EXU_WB_CONFLICT_CNT_EN
    logic [31:0]               conflict_cnt;
    logic [NUM_CH*16-1:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    exu_wb_arbiter #(
        .NUM_CH(NUM_CH), .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .RD_W(RD_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .ch_rd_addr(ch_rd_addr), .ch_tag(ch_tag), .ch_instr(ch_instr),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
        .wb_tag(wb_tag), .wb_instr(wb_instr), .wb_src(wb_src), .pending(pending)
`ifdef EXU_WB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
    );

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] tag;
        logic [31:0]     instr;
    } ent_t;

    typedef struct {
        logic [SRC_W-1:0] src;
        logic [31:0]      data;
    } ret_t;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    ent_t        mq [NUM_CH][$];
    int          m_rr;
    logic        m_valid;
    ent_t        m_out;
    logic [SRC_W-1:0] m_src;
    logic [31:0] m_conflict;
    logic [15:0] m_stall [NUM_CH];
    ret_t        ret_log [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per rising edge, using the channel queues as the FIFOs.
    task automatic modelStep();
        logic [NUM_CH-1:0] rdy;
        int busy;
        int g;
        ent_t e;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mq[i].delete();
                m_stall[i] = '0;
            end
            m_rr = NUM_CH - 1;
            m_valid = 1'b0;
            m_out = '0;
            m_src = '0;
            m_conflict = '0;
            return;
        end
        busy = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rdy[i] = (mq[i].size() < FIFO_DEPTH);
            if (mq[i].size() > 0) busy++;
            if (ch_valid[i] && !rdy[i] && m_stall[i] != 16'hFFFF) m_stall[i]++;
        end
        if (busy >= 2 && m_conflict != 32'hFFFF_FFFF) m_conflict++;
        g = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (g < 0 && mq[(m_rr + k) % NUM_CH].size() > 0) g = (m_rr + k) % NUM_CH;
        end
        if (g >= 0) begin
            m_out = mq[g].pop_front();
            m_src = SRC_W'(g);
            m_valid = 1'b1;
            m_rr = g;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i] && rdy[i] && ch_rd_addr[i*RD_W +: RD_W] != '0) begin
                e.data  = ch_data[i*XLEN +: XLEN];
                e.rd    = ch_rd_addr[i*RD_W +: RD_W];
                e.tag   = ch_tag[i*XLEN +: XLEN];
                e.instr = ch_instr[i*32 +: 32];
                mq[i].push_back(e);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        logic m_pend;
        @(negedge clk);
        if (check_en) begin
            m_pend = m_valid;
            for (int i = 0; i < NUM_CH; i++) begin
                if (mq[i].size() > 0) m_pend = 1'b1;
                checkOutput($sformatf("model_ready%0d", i), 32'(ch_ready[i]),
                            32'(mq[i].size() < FIFO_DEPTH));
            end
            checkOutput("model_wb_valid", 32'(wb_valid), 32'(m_valid));
            checkOutput("model_wb_data", wb_data, m_out.data);
            checkOutput("model_wb_rd", 32'(wb_rd_addr), 32'(m_out.rd));
            checkOutput("model_wb_tag", wb_tag, m_out.tag);
            checkOutput("model_wb_instr", wb_instr, m_out.instr);
            checkOutput("model_wb_src", 32'(wb_src), 32'(m_src));
            checkOutput("model_pending", 32'(pending), 32'(m_pend));
`ifdef EXU_WB_CONFLICT_CNT_EN
            checkOutput("model_conflict", conflict_cnt, m_conflict);
            for (int i = 0; i < NUM_CH; i++) begin
                checkOutput($sformatf("model_stall%0d", i), 32'(stall_cnt[i*16 +: 16]), 32'(m_stall[i]));
            end
`endif
        end
    end

    initial forever begin
        ret_t r;
        @(negedge clk);
        if (wb_valid === 1'b1) begin
            r.src = wb_src;
            r.data = wb_data;
            ret_log.push_back(r);
        end
    end

    task automatic applyStimulus(input int ch, input logic [31:0] data, input logic [4:0] rd);
        ch_valid[ch] = 1'b1;
        ch_data[ch*XLEN +: XLEN] = data;
        ch_rd_addr[ch*RD_W +: RD_W] = rd;
        ch_tag[ch*XLEN +: XLEN] = data ^ 32'h0F0F_0F0F;
        ch_instr[ch*32 +: 32] = data + 32'h13;
    endtask

    task automatic clearValid();
        ch_valid = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearValid();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : directed
        int n0, n2, k2;
        bit acc0, acc2;
        rst = 1'b1;
        ch_valid = '0;
        ch_data = '0;
        ch_rd_addr = '0;
        ch_tag = '0;
        ch_instr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);
        checkOutput("reset_ready", 32'(ch_ready), 32'hF);
        checkOutput("reset_wb_data", wb_data, 32'd0);
        checkOutput("reset_wb_src", 32'(wb_src), 32'd0);

        // Single source latency
        applyStimulus(0, 32'hDEAD_BEEF, 5'd5);
        @(negedge clk);
        clearValid();
        checkOutput("single_not_early", 32'(wb_valid), 32'd0);
        @(negedge clk);
        checkOutput("single_valid", 32'(wb_valid), 32'd1);
        checkOutput("single_data", wb_data, 32'hDEAD_BEEF);
        checkOutput("single_rd", 32'(wb_rd_addr), 32'd5);
        checkOutput("single_src", 32'(wb_src), 32'd0);
        @(negedge clk);
        checkOutput("single_one_cycle", 32'(wb_valid), 32'd0);
        checkOutput("single_hold_data", wb_data, 32'hDEAD_BEEF);

        // Four-way collision
        doReset();
        for (int i = 0; i < NUM_CH; i++) applyStimulus(i, 32'h100 + i, 5'(i + 1));
        @(negedge clk);
        clearValid();
        for (int i = 0; i < NUM_CH; i++) begin
            @(negedge clk);
            checkOutput("collide_valid", 32'(wb_valid), 32'd1);
            checkOutput("collide_src", 32'(wb_src), 32'(i));
            checkOutput("collide_rd", 32'(wb_rd_addr), 32'(i + 1));
        end
        checkOutput("collide_pending_last", 32'(pending), 32'd1);
        @(negedge clk);
        checkOutput("collide_pending_drop", 32'(pending), 32'd0);

        // Backpressure on ch2 with ch0 streaming
        doReset();
        ret_log.delete();
        n0 = 0;
        n2 = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 1) checkOutput("bp_ready2_high", 32'(ch_ready[2]), 32'd1);
            if (c == 2) checkOutput("bp_ready2_low", 32'(ch_ready[2]), 32'd0);
            if (n0 < 6) applyStimulus(0, 32'hA000_0000 + n0, 5'd10); else ch_valid[0] = 1'b0;
            if (n2 < 4) applyStimulus(2, 32'hB000_0000 + n2, 5'd20); else ch_valid[2] = 1'b0;
            acc0 = ch_valid[0] && ch_ready[0];
            acc2 = ch_valid[2] && ch_ready[2];
            @(negedge clk);
            if (acc0) n0++;
            if (acc2) n2++;
        end
        clearValid();
        repeat (4) @(negedge clk);
        checkOutput("bp_retired", 32'(ret_log.size()), 32'd10);
        if (ret_log.size() >= 4) begin
            checkOutput("bp_rr0", 32'(ret_log[0].src), 32'd0);
            checkOutput("bp_rr1", 32'(ret_log[1].src), 32'd2);
            checkOutput("bp_rr2", 32'(ret_log[2].src), 32'd0);
            checkOutput("bp_rr3", 32'(ret_log[3].src), 32'd2);
        end
        k2 = 0;
        foreach (ret_log[j]) begin
            if (ret_log[j].src == 2'd2) begin
                checkOutput("bp_ch2_order", ret_log[j].data, 32'hB000_0000 + k2);
                k2++;
            end
        end
        checkOutput("bp_ch2_count", 32'(k2), 32'd4);

        // x0 writes are accepted and dropped
        applyStimulus(1, 32'h1234, 5'd0);
        checkOutput("x0_ready", 32'(ch_ready[1]), 32'd1);
        @(negedge clk);
        clearValid();
        for (int c = 0; c < 3; c++) begin
            checkOutput("x0_no_wb", 32'(wb_valid), 32'd0);
            checkOutput("x0_no_pending", 32'(pending), 32'd0);
            @(negedge clk);
        end

        // Reset mid-operation, with pushes held through the reset edge
        applyStimulus(0, 32'hC000_0000, 5'd7);
        applyStimulus(3, 32'hD000_0000, 5'd8);
        @(negedge clk);
        applyStimulus(0, 32'hC000_0001, 5'd7);
        applyStimulus(3, 32'hD000_0001, 5'd8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clearValid();
        checkOutput("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_mid_pending", 32'(pending), 32'd0);
        checkOutput("rst_mid_ready", 32'(ch_ready), 32'hF);
        applyStimulus(0, 32'hE000_0000, 5'd9);
        applyStimulus(3, 32'hE000_0003, 5'd11);
        @(negedge clk);
        clearValid();
        @(negedge clk);
        checkOutput("rst_mid_first_src", 32'(wb_src), 32'd0);
        checkOutput("rst_mid_first_data", wb_data, 32'hE000_0000);
        @(negedge clk);
        checkOutput("rst_mid_second_src", 32'(wb_src), 32'd3);

`ifdef EXU_WB_CONFLICT_CNT_EN
        doReset();
        applyStimulus(1, 32'h11, 5'd1);
        applyStimulus(2, 32'h22, 5'd2);
        @(negedge clk);
        applyStimulus(1, 32'h12, 5'd1);
        applyStimulus(2, 32'h23, 5'd2);
        @(negedge clk);
        clearValid();
        repeat (4) @(negedge clk);
        checkOutput("conflict_three", conflict_cnt, 32'd3);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 32'h300 + c, 5'd3);
            applyStimulus(1, 32'h400 + c, 5'd4);
            @(negedge clk);
        end
        clearValid();
        repeat (6) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
